// File: rtl/c1_bus_master.sv
// c1_bus_master: round-robin master that sequences the A1/D1/C1 cache bus for two requesters
// Ports:
//   CLK, RESET_N            clock and synchronous active-low reset
//   rN_valid/ready          request handshake (N = 0, 1); ready is a one-cycle accept pulse
//   rN_cmd/addr/wdata       C1 command, 19-bit byte address, 32-bit write data
//   rN_done/err             one-cycle completion pulse, err set on rejected or aborted request
//   rdata                   read result, held until the next completion
//   A1, D1, C1              bus address, bidirectional bus data, bidirectional bus command
// Optional feature: define C1_TIMEOUT_EN to abort WAIT after RESP_TIMEOUT cycles with err.
module c1_bus_master #(
    parameter int ADDR1_BUS_SIZE  = 15,
    parameter int DATA1_BUS_SIZE  = 16,
    parameter int CTR1_BUS_SIZE   = 3,
    parameter int CACHE_ADDR_SIZE = 19,
    parameter int RESP_TIMEOUT    = 64
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       r0_valid,
    output logic                       r0_ready,
    input  logic [CTR1_BUS_SIZE-1:0]   r0_cmd,
    input  logic [CACHE_ADDR_SIZE-1:0] r0_addr,
    input  logic [31:0]                r0_wdata,
    output logic                       r0_done,
    output logic                       r0_err,
    input  logic                       r1_valid,
    output logic                       r1_ready,
    input  logic [CTR1_BUS_SIZE-1:0]   r1_cmd,
    input  logic [CACHE_ADDR_SIZE-1:0] r1_addr,
    input  logic [31:0]                r1_wdata,
    output logic                       r1_done,
    output logic                       r1_err,
    output logic [31:0]                rdata,
    output logic [ADDR1_BUS_SIZE-1:0]  A1,
    inout  wire  [DATA1_BUS_SIZE-1:0]  D1,
    inout  wire  [CTR1_BUS_SIZE-1:0]   C1
);
    typedef enum logic [2:0] {IDLE, ADDR1, ADDR2, WD2, WAIT, RD2, DONE} state_t;
    state_t                      state;
    logic [CTR1_BUS_SIZE-1:0]    cmd;
    logic [CACHE_ADDR_SIZE-1:0]  addr;
    logic [31:0]                 wdata;
    logic [DATA1_BUS_SIZE-1:0]   rd_lo;
    logic                        gnt;
    logic                        last_grant;
    logic                        c1_oe;
    logic                        d1_oe;
    logic [CTR1_BUS_SIZE-1:0]    c1_q;
    logic [DATA1_BUS_SIZE-1:0]   d1_q;
    logic                        pick;
    logic [CTR1_BUS_SIZE-1:0]    sel_cmd;
    logic                        is_write;
    logic [DATA1_BUS_SIZE-1:0]   wr_lo;
    logic                        rsp;
`ifdef C1_TIMEOUT_EN
    localparam int CW = $clog2(RESP_TIMEOUT + 1);
    logic [CW-1:0]               cnt;
`else
    logic                        unused_timeout;
    assign unused_timeout = RESP_TIMEOUT > 0;
`endif
    assign C1 = c1_oe ? c1_q : 'z;
    assign D1 = d1_oe ? d1_q : 'z;
    // Lone requester wins; on contention the one not served last time wins.
    assign pick     = (r0_valid && r1_valid) ? !last_grant : r1_valid;
    assign sel_cmd  = pick ? r1_cmd : r0_cmd;
    assign is_write = cmd[2] && (cmd[1:0] != 2'b00);
    assign wr_lo    = (cmd == 3'b101) ? {8'h00, wdata[7:0]} : wdata[15:0];
    assign rsp      = (C1 == '1);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= IDLE;
            cmd        <= '0;
            addr       <= '0;
            wdata      <= '0;
            rd_lo      <= '0;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            c1_oe      <= 1'b1;
            c1_q       <= '0;
            d1_oe      <= 1'b0;
            d1_q       <= '0;
            A1         <= '0;
            rdata      <= '0;
            r0_ready   <= 1'b0;
            r1_ready   <= 1'b0;
            r0_done    <= 1'b0;
            r1_done    <= 1'b0;
            r0_err     <= 1'b0;
            r1_err     <= 1'b0;
`ifdef C1_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            r0_ready <= 1'b0;
            r1_ready <= 1'b0;
            r0_done  <= 1'b0;
            r1_done  <= 1'b0;
            r0_err   <= 1'b0;
            r1_err   <= 1'b0;
            case (state)
                IDLE: if (r0_valid || r1_valid) begin
                    gnt        <= pick;
                    last_grant <= pick;
                    r0_ready   <= !pick;
                    r1_ready   <= pick;
                    cmd        <= sel_cmd;
                    addr       <= pick ? r1_addr : r0_addr;
                    wdata      <= pick ? r1_wdata : r0_wdata;
                    // NOP command is rejected on the spot without touching the bus.
                    if (sel_cmd == '0) begin
                        state   <= DONE;
                        r0_done <= !pick;
                        r1_done <= pick;
                        r0_err  <= !pick;
                        r1_err  <= pick;
                    end else begin
                        state <= ADDR1;
                        c1_q  <= sel_cmd;
                        A1    <= pick ? r1_addr[CACHE_ADDR_SIZE-1:4] : r0_addr[CACHE_ADDR_SIZE-1:4];
                    end
                end
                ADDR1: begin
                    state <= ADDR2;
                    c1_oe <= 1'b0;
                    A1    <= ADDR1_BUS_SIZE'(addr[3:0]);
                    d1_oe <= is_write;
                    d1_q  <= wr_lo;
                end
                ADDR2: if (cmd == 3'b111) begin
                    state <= WD2;
                    d1_q  <= wdata[31:16];
                end else begin
                    state <= WAIT;
                    d1_oe <= 1'b0;
`ifdef C1_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                WD2: begin
                    state <= WAIT;
                    d1_oe <= 1'b0;
`ifdef C1_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                WAIT: if (rsp) begin
                    if (cmd == 3'b001) rdata <= {24'h0, D1[7:0]};
                    if (cmd == 3'b010) rdata <= {16'h0, D1};
                    if (cmd == 3'b011) begin
                        state <= RD2;
                        rd_lo <= D1;
                    end else begin
                        state   <= DONE;
                        c1_oe   <= 1'b1;
                        c1_q    <= '0;
                        r0_done <= !gnt;
                        r1_done <= gnt;
                    end
                end
`ifdef C1_TIMEOUT_EN
                else if (cnt == CW'(RESP_TIMEOUT - 1)) begin
                    state   <= DONE;
                    c1_oe   <= 1'b1;
                    c1_q    <= '0;
                    r0_done <= !gnt;
                    r1_done <= gnt;
                    r0_err  <= !gnt;
                    r1_err  <= gnt;
                end else cnt <= cnt + 1'b1;
`endif
                RD2: begin
                    state   <= DONE;
                    rdata   <= {D1, rd_lo};
                    c1_oe   <= 1'b1;
                    c1_q    <= '0;
                    r0_done <= !gnt;
                    r1_done <= gnt;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_c1_bus_master.sv
// tb_c1_bus_master: randomized bench with a transaction-level expected-timeline model for c1_bus_master
module tb_c1_bus_master;
    localparam int TO   = 8;
    localparam int NCYC = 3000;
`ifdef C1_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [15:0] DREL = 16'hFFFF;

    typedef struct {
        logic [2:0]  cmd;
        logic [18:0] addr;
        logic [31:0] wd;
        int          w;
        logic [15:0] lo;
        logic [15:0] hi;
    } req_t;

    typedef struct {
        logic [1:0]  rdy;
        logic [1:0]  done;
        logic        err;
        logic [14:0] a1;
        logic [2:0]  c1;
        logic [15:0] d1;
        logic        rsp;
        logic        d1drv;
        logic [15:0] bd;
        logic        is_wait;
        logic [31:0] rd;
    } ent_t;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic [2:0]  r0_cmd = '0, r1_cmd = '0;
    logic [18:0] r0_addr = '0, r1_addr = '0;
    logic [31:0] r0_wdata = '0, r1_wdata = '0;
    logic        r0_ready, r1_ready, r0_done, r1_done, r0_err, r1_err;
    logic [31:0] rdata;
    logic [14:0] A1;
    tri1  [15:0] D1;
    tri0  [2:0]  C1;
    logic        tb_c1_en = 1'b0, tb_d1_en = 1'b0;
    logic [15:0] tb_d1 = '0;

    assign C1 = tb_c1_en ? 3'b111 : 3'bzzz;
    assign D1 = tb_d1_en ? tb_d1 : 16'hzzzz;

    c1_bus_master #(.RESP_TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_cmd(r0_cmd), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_done(r0_done), .r0_err(r0_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_cmd(r1_cmd), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_done(r1_done), .r1_err(r1_err),
        .rdata(rdata), .A1(A1), .D1(D1), .C1(C1)
    );

    always #5 CLK = ~CLK;

    int          nerr = 0, nchk = 0, nrst = 0;
    ent_t        plan[$];
    req_t        dq0[$], dq1[$];
    req_t        cur[2];
    logic [1:0]  vld = '0;
    logic [14:0] a1_m = '0;
    logic [31:0] rd_m = '0;
    logic        last_m = 1'b1;
    int          glog[$];
    logic [31:0] dlog[$];
    logic [14:0] a1_log[64];
    logic [15:0] d1_log[64];
    logic        d0_log[64];
    bit          force_rst = 1'b1;

    task automatic chk(input string n, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", n, cyc, act, exp);
        end
    endtask

    function automatic req_t mk(input logic [2:0] c, input logic [18:0] a, input logic [31:0] wd,
                                input int w, input logic [15:0] lo, input logic [15:0] hi);
        req_t r;
        r.cmd = c; r.addr = a; r.wd = wd; r.w = w; r.lo = lo; r.hi = hi;
        return r;
    endfunction

    function automatic ent_t base();
        ent_t e;
        e.rdy = '0; e.done = '0; e.err = 1'b0; e.a1 = a1_m; e.c1 = 3'b000; e.d1 = DREL;
        e.rsp = 1'b0; e.d1drv = 1'b0; e.bd = '0; e.is_wait = 1'b0; e.rd = rd_m;
        return e;
    endfunction

    // Expected per-cycle bus timeline of one granted transaction, from accept to completion.
    task automatic build(input int k, input req_t r);
        ent_t        e;
        logic [14:0] lo4;
        logic [31:0] nrd;
        bit          tmo;
        int          nw;
        nrd = rd_m;
        if (r.cmd == 3'b000) begin
            e = base(); e.rdy[k] = 1'b1; e.done[k] = 1'b1; e.err = 1'b1;
            plan.push_back(e);
            return;
        end
        lo4 = {11'b0, r.addr[3:0]};
        e = base(); e.rdy[k] = 1'b1; e.c1 = r.cmd; e.a1 = r.addr[18:4];
        plan.push_back(e);
        e = base(); e.c1 = 3'b000; e.a1 = lo4;
        if (r.cmd >= 3'd5) e.d1 = (r.cmd == 3'd5) ? {8'h00, r.wd[7:0]} : r.wd[15:0];
        plan.push_back(e);
        if (r.cmd == 3'd7) begin
            e = base(); e.a1 = lo4; e.d1 = r.wd[31:16];
            plan.push_back(e);
        end
        tmo = TO_EN && (r.w >= TO);
        nw  = tmo ? TO : r.w;
        for (int i = 0; i < nw; i++) begin
            e = base(); e.a1 = lo4; e.is_wait = 1'b1;
            plan.push_back(e);
        end
        if (!tmo) begin
            e = base(); e.a1 = lo4; e.is_wait = 1'b1; e.rsp = 1'b1; e.bd = r.lo;
            plan.push_back(e);
            if (r.cmd == 3'd1) nrd = {24'h0, r.lo[7:0]};
            if (r.cmd == 3'd2) nrd = {16'h0, r.lo};
            if (r.cmd == 3'd3) begin
                nrd = {r.hi, r.lo};
                e = base(); e.a1 = lo4; e.d1drv = 1'b1; e.bd = r.hi;
                plan.push_back(e);
            end
        end
        e = base(); e.a1 = lo4; e.done[k] = 1'b1; e.err = tmo; e.rd = nrd;
        plan.push_back(e);
    endtask

    task automatic new_req(input int k);
        req_t r;
        if (k == 0 && dq0.size() > 0) r = dq0.pop_front();
        else if (k == 1 && dq1.size() > 0) r = dq1.pop_front();
        else if ($urandom_range(0, 2) == 0)
            r = mk(3'($urandom_range(0, 7)), 19'($urandom), $urandom, $urandom_range(0, 9),
                   16'($urandom), 16'($urandom));
        else return;
        cur[k] = r;
        vld[k] = 1'b1;
    endtask

    initial begin
        ent_t e;
        bit   idle;
        int   k;
        dq0.push_back(mk(3'd1, 19'h00123, 32'h0, 2, 16'h00A5, 16'h0));
        dq0.push_back(mk(3'd3, 19'h00040, 32'h0, 1, 16'h5678, 16'h1234));
        dq0.push_back(mk(3'd2, 19'h10008, 32'h0, 0, 16'hC0DE, 16'h0));
        dq0.push_back(mk(3'd2, 19'h7FFFF, 32'h0, 4, 16'hFFFE, 16'h0));
        dq0.push_back(mk(3'd2, 19'h00000, 32'h0, 3, 16'h0001, 16'h0));
        dq0.push_back(mk(3'd1, 19'h00200, 32'h0, 110, 16'h0042, 16'h0));
        dq1.push_back(mk(3'd7, 19'h01100, 32'hDEADBEEF, 2, 16'h0, 16'h0));
        dq1.push_back(mk(3'd1, 19'h00010, 32'h0, 0, 16'h3C5A, 16'h0));
        dq1.push_back(mk(3'd5, 19'h00305, 32'hFFFF_FFC3, 1, 16'h0, 16'h0));
        dq1.push_back(mk(3'd0, 19'h00001, 32'h0, 0, 16'h0, 16'h0));
        dq1.push_back(mk(3'd4, 19'h0ABCD, 32'h0, 2, 16'h0, 16'h0));
        dq1.push_back(mk(3'd6, 19'h12345, 32'h89AB_CDEF, 0, 16'h0, 16'h0));
        dq1.push_back(mk(3'd1, 19'h00020, 32'h0, 1, 16'h77FF, 16'h0));
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge CLK);
            #1;
            tb_c1_en = 1'b0;
            tb_d1_en = 1'b0;
            @(negedge CLK);
            if (plan.size() > 0) begin
                e = plan.pop_front();
                idle = 1'b0;
            end else begin
                e = base();
                idle = 1'b1;
            end
            a1_m = e.a1;
            rd_m = e.rd;
            if (cyc == 0) begin
                chk("reset_C1", cyc, 32'(C1), 32'h0);
                chk("reset_A1", cyc, 32'(A1), 32'h0);
                chk("reset_rdata", cyc, rdata, 32'h0);
            end
            chk("r0_ready", cyc, 32'(r0_ready), 32'(e.rdy[0]));
            chk("r1_ready", cyc, 32'(r1_ready), 32'(e.rdy[1]));
            chk("r0_done", cyc, 32'(r0_done), 32'(e.done[0]));
            chk("r1_done", cyc, 32'(r1_done), 32'(e.done[1]));
            chk("r0_err", cyc, 32'(r0_err), 32'(e.done[0] & e.err));
            chk("r1_err", cyc, 32'(r1_err), 32'(e.done[1] & e.err));
            chk("A1", cyc, 32'(A1), 32'(e.a1));
            chk("C1", cyc, 32'(C1), 32'(e.c1));
            chk("D1", cyc, 32'(D1), 32'(e.d1));
            chk("rdata", cyc, rdata, e.rd);
            if (cyc < 64) begin
                a1_log[cyc] = A1;
                d1_log[cyc] = D1;
                d0_log[cyc] = r0_done;
            end
            if (e.done != 2'b00) dlog.push_back(rdata);
            if (e.rsp) begin
                tb_c1_en = 1'b1;
                tb_d1    = e.bd;
                tb_d1_en = 1'b1;
            end
            if (e.d1drv) begin
                tb_d1    = e.bd;
                tb_d1_en = 1'b1;
            end
            if (cyc < 1) RESET_N = 1'b0;
            else if (RESET_N && e.is_wait && !e.rsp && cyc > 400 &&
                     (force_rst || $urandom_range(0, 39) == 0)) begin
                RESET_N = 1'b0;
                force_rst = 1'b0;
                nrst++;
                plan.delete();
                a1_m = '0;
                rd_m = '0;
                last_m = 1'b1;
            end else RESET_N = 1'b1;
            for (int j = 0; j < 2; j++) begin
                if (vld[j] && e.rdy[j]) vld[j] = 1'b0;
                if (!vld[j]) new_req(j);
            end
            r0_valid = vld[0]; r0_cmd = cur[0].cmd; r0_addr = cur[0].addr; r0_wdata = cur[0].wd;
            r1_valid = vld[1]; r1_cmd = cur[1].cmd; r1_addr = cur[1].addr; r1_wdata = cur[1].wd;
            if (idle && RESET_N && vld != 2'b00) begin
                k = (vld == 2'b11) ? int'(!last_m) : int'(vld[1]);
                last_m = k[0];
                glog.push_back(k);
                build(k, cur[k]);
            end
        end
        chk("t1_A1_hi", 2, 32'(a1_log[2]), 32'h0012);
        chk("t1_A1_lo", 3, 32'(a1_log[3]), 32'h0003);
        chk("t1_r0_done", 7, 32'(d0_log[7]), 32'h1);
        chk("t2_A1_hi", 9, 32'(a1_log[9]), 32'h0110);
        chk("t2_A1_lo", 10, 32'(a1_log[10]), 32'h0000);
        chk("t2_D1_lo", 10, 32'(d1_log[10]), 32'hBEEF);
        chk("t2_D1_hi", 11, 32'(d1_log[11]), 32'hDEAD);
        chk("t1_rdata", 0, dlog[0], 32'h000000A5);
        chk("t2_rdata_kept", 0, dlog[1], 32'h000000A5);
        chk("t4_rdata_r32", 0, dlog[2], 32'h12345678);
        for (int i = 0; i < 8; i++) chk("grant_order", i, 32'(glog[i]), 32'(i % 2));
        chk("mid_reset_seen", 0, 32'(nrst > 0), 32'h1);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
